regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_read_port.sv | 54 +++++
 rtl/regfile_sb.sv | 141 ++++++++++++++
 tb/tb_regfile_sb.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg -- shared constants and types for the scoreboarded register file.
//
// Contents:
//   DEFAULT_ADDR_WIDTH  default register index width (32 entries)
//   DEFAULT_DATA_WIDTH  default register data width
//   reg_idx_t           register index type at the default width

package rf_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port -- one combinational read path of the scoreboarded register file.
//
// Selects between the hardwired zero register, the same-cycle writeback
// bypass and the committed storage word. It also looks up the busy bit so
// that the consumer knows whether the operand is ready.
//
// Ports:
//   raddr        read index
//   stored_data  committed contents of rf[raddr] (selected by the parent)
//   busy         full busy vector, one bit per entry
//   bypass_en    writeback strobe, already suppressed during reset
//   wb_addr      writeback index
//   wb_data      writeback data
//   rdata        operand value
//   rvalid       operand ready (not waiting on an outstanding producer)

module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic [ADDR_WIDTH-1:0]    raddr,
    input  logic [DATA_WIDTH-1:0]    stored_data,
    input  logic [2**ADDR_WIDTH-1:0] busy,
    input  logic                     bypass_en,
    input  logic [ADDR_WIDTH-1:0]    wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     rvalid
);

    logic is_zero;
    logic hit_wb;

    assign is_zero = (ZERO_REG != 0) && (raddr == '0);
    assign hit_wb  = bypass_en && (wb_addr == raddr);

    // Zero register takes priority over the bypass: a writeback to x0 is
    // dropped, so forwarding its data would expose a value that never lands.
    always_comb begin
        rdata  = stored_data;
        rvalid = !busy[raddr];
        if (is_zero) begin
            rdata  = '0;
            rvalid = 1'b1;
        end else if (hit_wb) begin
            rdata  = wb_data;
            rvalid = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with a per-entry busy scoreboard.
//
// Issue marks a destination busy (alloc), writeback stores data and clears
// the busy bit. Reads are combinational with same-cycle writeback bypass.
// A second allocation to a still-busy destination is stalled (WAW).
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   alloc_valid   request to mark alloc_addr busy
//   alloc_addr    destination being allocated
//   alloc_ready   allocation accepted this cycle if alloc_valid
//   wb_valid      writeback strobe
//   wb_addr       writeback index
//   wb_data       writeback data
//   raddr         packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata         packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rvalid        per-port operand-ready flags
//   busy_cnt      number of entries currently busy (registered)
//   dbg_addr      debug index
//   dbg_data      committed contents of rf[dbg_addr], no bypass

module regfile_sb
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alloc_valid,
    input  logic [ADDR_WIDTH-1:0]            alloc_addr,
    output logic                             alloc_ready,
    input  logic                             wb_valid,
    input  logic [ADDR_WIDTH-1:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0]            wb_data,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RPORTS-1:0]            rvalid,
    output logic [ADDR_WIDTH:0]              busy_cnt,
    input  logic [ADDR_WIDTH-1:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0]            dbg_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [CNT_W-1:0]      busy_cnt_q;
    logic [CNT_W-1:0]      busy_cnt_d;

    logic alloc_is_zero;
    logic wb_is_zero;
    logic alloc_fire;
    logic wb_fire;
    logic cnt_inc;
    logic cnt_dec;
    logic bypass_en;

    assign alloc_is_zero = (ZERO_REG != 0) && (alloc_addr == '0);
    assign wb_is_zero    = (ZERO_REG != 0) && (wb_addr == '0);

    // x0 is always ready and never marked, so an alloc to it is a no-op.
    assign alloc_ready = alloc_is_zero || !busy_q[alloc_addr];
    assign alloc_fire  = alloc_valid && alloc_ready && !alloc_is_zero;
    assign wb_fire     = wb_valid && !wb_is_zero;

    // Writeback clears first, then a same-index allocation re-marks the
    // entry: the newly issued producer is the one consumers must wait for.
    always_comb begin
        busy_d = busy_q;
        if (wb_fire) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (alloc_fire) begin
            busy_d[alloc_addr] = 1'b1;
        end
    end

    // An accepted alloc always targets a clear bit, so it always adds one.
    // A writeback only removes one if the bit was set and is not immediately
    // re-marked by an allocation to the same index.
    assign cnt_inc = alloc_fire;
    assign cnt_dec = wb_fire && busy_q[wb_addr] && !(alloc_fire && (alloc_addr == wb_addr));

    always_comb begin
        busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_fire) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign busy_cnt = busy_cnt_q;
    assign dbg_data = rf_q[dbg_addr];

    // A writeback presented while reset is held is discarded, so it must not
    // be forwarded either.
    assign bypass_en = wb_valid && !rst;

    for (genvar i = 0; i < int'(NUM_RPORTS); i++) begin : g_rport
        logic [ADDR_WIDTH-1:0] port_addr;

        assign port_addr = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

        rf_read_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .ZERO_REG   (ZERO_REG)
        ) u_read_port (
            .raddr       (port_addr),
            .stored_data (rf_q[port_addr]),
            .busy        (busy_q),
            .bypass_en   (bypass_en),
            .wb_addr     (wb_addr),
            .wb_data     (wb_data),
            .rdata       (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .rvalid      (rvalid[i])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- self-checking bench for regfile_sb (4 read ports).
// Inputs change on the falling edge; outputs are sampled before the next
// rising edge. Expected values come from a small behavioural model and pass
// through a queue before being compared with the DUT.

module tb_regfile_sb;
    import rf_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NP = 4;

    logic             clk;
    logic             rst;
    logic             alloc_valid;
    reg_idx_t         alloc_addr;
    logic             alloc_ready;
    logic             wb_valid;
    reg_idx_t         wb_addr;
    logic [DW-1:0]    wb_data;
    logic [NP*AW-1:0] raddr;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]    rvalid;
    logic [AW:0]      busy_cnt;
    reg_idx_t         dbg_addr;
    logic [DW-1:0]    dbg_data;

    int total;
    int bad;

    // Behavioural model of committed state.
    logic [DW-1:0] m_rf [32];
    logic [31:0]   m_busy;

    logic [63:0] exp_q [$];
    logic [63:0] e;

    regfile_sb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_RPORTS (NP),
        .ZERO_REG   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .raddr       (raddr),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .busy_cnt    (busy_cnt),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_busy = '0;
    endtask

    // Returns {rvalid, rdata} expected for a read of index a this cycle.
    function automatic logic [32:0] model_read(input reg_idx_t a);
        if (a == 0) return {1'b1, 32'h0};
        if (wb_valid && !rst && wb_addr == a) return {1'b1, wb_data};
        return {!m_busy[a], m_rf[a]};
    endfunction

    function automatic logic model_ready();
        return (alloc_addr == 0) || !m_busy[alloc_addr];
    endfunction

    function automatic logic [AW:0] model_cnt();
        return ($countones(m_busy)) & 6'h3f;
    endfunction

    // Advance one clock, update the model from the inputs seen at the edge,
    // and return at the falling edge ready for the next stimulus.
    task automatic step();
        logic acc;
        @(posedge clk);
        if (!rst) begin
            acc = alloc_valid && alloc_addr != 0 && !m_busy[alloc_addr];
            if (wb_valid && wb_addr != 0) begin
                m_rf[wb_addr]   = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (acc) m_busy[alloc_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic set_raddr(input reg_idx_t a0, input reg_idx_t a1, input reg_idx_t a2,
                             input reg_idx_t a3);
        raddr = {a3, a2, a1, a0};
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        dbg_addr    = '0;
        set_raddr(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_clear();
        // Held in reset with a writeback presented: it must not be bypassed.
        @(negedge clk);
        wb_valid = 1'b1;
        wb_addr  = 5;
        wb_data  = 32'hABCD_0123;
        alloc_valid = 1'b1;
        alloc_addr  = 5;
        set_raddr(5, 0, 5, 0);
        #2;
        for (int p = 0; p < NP; p++) exp_q.push_back(64'(model_read(raddr[p*AW +: AW])));
        exp_q.push_back(64'hf);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        for (int p = 0; p < NP; p++) begin
            e = exp_q.pop_front();
            total++;
            if (rdata[p*DW +: DW] !== e[31:0]) begin
                bad++;
                $display("FAIL rst_rdata%0d: got %h expected %h", p, rdata[p*DW +: DW], e[31:0]);
            end
        end
        e = exp_q.pop_front();
        total++;
        if (rvalid !== e[3:0]) begin
            bad++;
            $display("FAIL rst_rvalid: got %b expected %b", rvalid, e[3:0]);
        end
        e = exp_q.pop_front();
        total++;
        if (busy_cnt !== e[AW:0]) begin
            bad++;
            $display("FAIL rst_busy_cnt: got %0d expected %0d", busy_cnt, e[AW:0]);
        end
        e = exp_q.pop_front();
        total++;
        if (alloc_ready !== e[0]) begin
            bad++;
            $display("FAIL rst_alloc_ready: got %b expected %b", alloc_ready, e[0]);
        end
        @(negedge clk);
        // Released: inputs ignored during reset must have left nothing behind.
        rst = 1'b0;
        idle_inputs();
        set_raddr(5, 0, 5, 0);
        alloc_addr = 5;
        #2;
        for (int p = 0; p < NP; p++) exp_q.push_back(64'(model_read(raddr[p*AW +: AW])));
        exp_q.push_back(64'(model_cnt()));
        for (int p = 0; p < NP; p++) begin
            e = exp_q.pop_front();
            total++;
            if ({rvalid[p], rdata[p*DW +: DW]} !== e[32:0]) begin
                bad++;
                $display("FAIL post_rst_port%0d: got %b/%h expected %b/%h", p, rvalid[p],
                         rdata[p*DW +: DW], e[32], e[31:0]);
            end
        end
        e = exp_q.pop_front();
        total++;
        if (busy_cnt !== e[AW:0] || alloc_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_cnt_ready: got %0d/%b expected %0d/1", busy_cnt, alloc_ready,
                     e[AW:0]);
        end
    endtask

    task automatic test_alloc_bypass();
        alloc_valid = 1'b1;
        alloc_addr  = 5;
        step();
        alloc_valid = 1'b0;
        set_raddr(5, 5, 0, 0);
        #2;
        exp_q.push_back({63'h0, model_read(5)});
        exp_q.push_back({63'h0, model_ready()});
        exp_q.push_back(64'(model_cnt()));
        e = exp_q.pop_front();
        total++;
        if (rvalid[0] !== e[32]) begin
            bad++;
            $display("FAIL busy_rvalid: got %b expected %b", rvalid[0], e[32]);
        end
        e = exp_q.pop_front();
        total++;
        if (alloc_ready !== e[0]) begin
            bad++;
            $display("FAIL waw_ready: got %b expected %b", alloc_ready, e[0]);
        end
        e = exp_q.pop_front();
        total++;
        if (busy_cnt !== e[AW:0]) begin
            bad++;
            $display("FAIL alloc_cnt: got %0d expected %0d", busy_cnt, e[AW:0]);
        end
        step();
        wb_valid = 1'b1;
        wb_addr  = 5;
        wb_data  = 32'hDEAD_BEEF;
        #2;
        exp_q.push_back(64'(model_read(5)));
        e = exp_q.pop_front();
        total++;
        if ({rvalid[0], rdata[31:0]} !== e[32:0]) begin
            bad++;
            $display("FAIL bypass: got %b/%h expected %b/%h", rvalid[0], rdata[31:0], e[32],
                     e[31:0]);
        end
        step();
        wb_valid = 1'b0;
        dbg_addr = 5;
        #2;
        exp_q.push_back(64'(model_cnt()));
        exp_q.push_back(64'(m_rf[5]));
        exp_q.push_back(64'(model_read(5)));
        e = exp_q.pop_front();
        total++;
        if (busy_cnt !== e[AW:0]) begin
            bad++;
            $display("FAIL wb_cnt: got %0d expected %0d", busy_cnt, e[AW:0]);
        end
        e = exp_q.pop_front();
        total++;
        if (dbg_data !== e[31:0]) begin
            bad++;
            $display("FAIL dbg5: got %h expected %h", dbg_data, e[31:0]);
        end
        e = exp_q.pop_front();
        total++;
        if ({rvalid[0], rdata[31:0]} !== e[32:0]) begin
            bad++;
            $display("FAIL stored_read5: got %b/%h expected %b/%h", rvalid[0], rdata[31:0], e[32],
                     e[31:0]);
        end
    endtask

    task automatic test_waw_stall();
        alloc_valid = 1'b1;
        alloc_addr  = 7;
        step();
        wb_valid = 1'b1;
        wb_addr  = 7;
        wb_data  = 32'h1;
        #2;
        exp_q.push_back({63'h0, model_ready()});
        e = exp_q.pop_front();
        total++;
        if (alloc_ready !== e[0]) begin
            bad++;
            $display("FAIL stall_ready: got %b expected %b", alloc_ready, e[0]);
        end
        step();
        wb_valid = 1'b0;
        #2;
        exp_q.push_back(64'(model_cnt()));
        exp_q.push_back({63'h0, model_ready()});
        e = exp_q.pop_front();
        total++;
        if (busy_cnt !== e[AW:0]) begin
            bad++;
            $display("FAIL stall_cnt_dec: got %0d expected %0d", busy_cnt, e[AW:0]);
        end
        e = exp_q.pop_front();
        total++;
        if (alloc_ready !== e[0]) begin
            bad++;
            $display("FAIL retry_ready: got %b expected %b", alloc_ready, e[0]);
        end
        step();
        alloc_valid = 1'b0;
        #2;
        exp_q.push_back(64'(model_cnt()));
        e = exp_q.pop_front();
        total++;
        if (busy_cnt !== e[AW:0]) begin
            bad++;
            $display("FAIL retry_cnt: got %0d expected %0d", busy_cnt, e[AW:0]);
        end
    endtask

    task automatic test_zero_reg();
        wb_valid    = 1'b1;
        wb_addr     = 0;
        wb_data     = 32'h1234;
        alloc_valid = 1'b1;
        alloc_addr  = 0;
        set_raddr(0, 0, 0, 0);
        #2;
        exp_q.push_back(64'(model_read(0)));
        exp_q.push_back({63'h0, model_ready()});
        e = exp_q.pop_front();
        total++;
        if ({rvalid[0], rdata[31:0]} !== e[32:0]) begin
            bad++;
            $display("FAIL zero_read: got %b/%h expected %b/%h", rvalid[0], rdata[31:0], e[32],
                     e[31:0]);
        end
        e = exp_q.pop_front();
        total++;
        if (alloc_ready !== e[0]) begin
            bad++;
            $display("FAIL zero_ready: got %b expected %b", alloc_ready, e[0]);
        end
        step();
        idle_inputs();
        #2;
        exp_q.push_back(64'(model_cnt()));
        exp_q.push_back(64'(m_rf[0]));
        e = exp_q.pop_front();
        total++;
        if (busy_cnt !== e[AW:0]) begin
            bad++;
            $display("FAIL zero_cnt: got %0d expected %0d", busy_cnt, e[AW:0]);
        end
        e = exp_q.pop_front();
        total++;
        if (dbg_data !== e[31:0]) begin
            bad++;
            $display("FAIL zero_dbg: got %h expected %h", dbg_data, e[31:0]);
        end
    endtask

    task automatic test_same_index();
        alloc_valid = 1'b1;
        alloc_addr  = 9;
        wb_valid    = 1'b1;
        wb_addr     = 9;
        wb_data     = 32'h0000_0099;
        step();
        idle_inputs();
        dbg_addr = 9;
        set_raddr(9, 0, 0, 0);
        #2;
        exp_q.push_back(64'(model_cnt()));
        exp_q.push_back(64'(model_read(9)));
        exp_q.push_back(64'(m_rf[9]));
        e = exp_q.pop_front();
        total++;
        if (busy_cnt !== e[AW:0]) begin
            bad++;
            $display("FAIL same_idx_cnt: got %0d expected %0d", busy_cnt, e[AW:0]);
        end
        e = exp_q.pop_front();
        total++;
        if (rvalid[0] !== e[32]) begin
            bad++;
            $display("FAIL same_idx_busy: got %b expected %b", rvalid[0], e[32]);
        end
        e = exp_q.pop_front();
        total++;
        if (dbg_data !== e[31:0]) begin
            bad++;
            $display("FAIL same_idx_data: got %h expected %h", dbg_data, e[31:0]);
        end
    endtask

    task automatic test_mid_reset();
        for (int r = 1; r <= 3; r++) begin
            alloc_valid = 1'b1;
            alloc_addr  = reg_idx_t'(r);
            wb_valid    = 1'b1;
            wb_addr     = reg_idx_t'(r);
            wb_data     = 32'h100 + 32'(r);
            step();
        end
        alloc_valid = 1'b1;
        alloc_addr  = 1;
        wb_valid    = 1'b0;
        step();
        idle_inputs();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_clear();
        #1;
        exp_q.push_back(64'(model_cnt()));
        e = exp_q.pop_front();
        total++;
        if (busy_cnt !== e[AW:0]) begin
            bad++;
            $display("FAIL async_rst_cnt: got %0d expected %0d", busy_cnt, e[AW:0]);
        end
        for (int r = 1; r <= 3; r++) begin
            dbg_addr = reg_idx_t'(r);
            #1;
            exp_q.push_back(64'(m_rf[r]));
            e = exp_q.pop_front();
            total++;
            if (dbg_data !== e[31:0]) begin
                bad++;
                $display("FAIL async_rst_dbg%0d: got %h expected %h", r, dbg_data, e[31:0]);
            end
        end
        step();
        wb_valid = 1'b1;
        wb_addr  = 1;
        wb_data  = 32'h55;
        step();
        idle_inputs();
        set_raddr(1, 0, 0, 0);
        #2;
        exp_q.push_back(64'(model_read(1)));
        e = exp_q.pop_front();
        total++;
        if ({rvalid[0], rdata[31:0]} !== e[32:0]) begin
            bad++;
            $display("FAIL post_rst_wb: got %b/%h expected %b/%h", rvalid[0], rdata[31:0], e[32],
                     e[31:0]);
        end
    endtask

    task automatic test_four_ports();
        for (int r = 2; r <= 4; r++) begin
            wb_valid = 1'b1;
            wb_addr  = reg_idx_t'(r);
            wb_data  = 32'h11 * 32'(r);
            step();
        end
        wb_valid = 1'b1;
        wb_addr  = 3;
        wb_data  = 32'hA5;
        set_raddr(1, 2, 3, 4);
        #2;
        for (int p = 0; p < NP; p++) exp_q.push_back(64'(model_read(raddr[p*AW +: AW])));
        for (int p = 0; p < NP; p++) begin
            e = exp_q.pop_front();
            total++;
            if ({rvalid[p], rdata[p*DW +: DW]} !== e[32:0]) begin
                bad++;
                $display("FAIL quad_port%0d: got %b/%h expected %b/%h", p, rvalid[p],
                         rdata[p*DW +: DW], e[32], e[31:0]);
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 60; c++) begin
            alloc_valid = 1'($urandom_range(0, 1));
            alloc_addr  = reg_idx_t'($urandom_range(0, 7));
            wb_valid    = 1'($urandom_range(0, 1));
            wb_addr     = reg_idx_t'($urandom_range(0, 7));
            wb_data     = $urandom;
            dbg_addr    = reg_idx_t'($urandom_range(0, 7));
            for (int p = 0; p < NP; p++) raddr[p*AW +: AW] = reg_idx_t'($urandom_range(0, 7));
            #2;
            for (int p = 0; p < NP; p++) exp_q.push_back(64'(model_read(raddr[p*AW +: AW])));
            exp_q.push_back({63'h0, model_ready()});
            exp_q.push_back(64'(model_cnt()));
            exp_q.push_back(64'(m_rf[dbg_addr]));
            for (int p = 0; p < NP; p++) begin
                e = exp_q.pop_front();
                total++;
                if ({rvalid[p], rdata[p*DW +: DW]} !== e[32:0]) begin
                    bad++;
                    $display("FAIL rand%0d_port%0d: got %b/%h expected %b/%h", c, p, rvalid[p],
                             rdata[p*DW +: DW], e[32], e[31:0]);
                end
            end
            e = exp_q.pop_front();
            total++;
            if (alloc_ready !== e[0]) begin
                bad++;
                $display("FAIL rand%0d_ready: got %b expected %b", c, alloc_ready, e[0]);
            end
            e = exp_q.pop_front();
            total++;
            if (busy_cnt !== e[AW:0]) begin
                bad++;
                $display("FAIL rand%0d_cnt: got %0d expected %0d", c, busy_cnt, e[AW:0]);
            end
            e = exp_q.pop_front();
            total++;
            if (dbg_data !== e[31:0]) begin
                bad++;
                $display("FAIL rand%0d_dbg: got %h expected %h", c, dbg_data, e[31:0]);
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alloc_bypass();
        test_waw_stall();
        test_zero_reg();
        test_same_index();
        test_mid_reset();
        test_four_ports();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
